// File: rtl/addr_calc_pkg.sv
// Shared field layout for the sprite/tile address generator, so display
// components assemble pattern and placement words identically.
package addr_calc_pkg;

  localparam int unsigned PAT_FIELD_W  = 16;
  localparam int unsigned PAT_INFO_W   = 5 * PAT_FIELD_W;
  localparam int unsigned SPR_COORD_W  = 10;
  localparam int unsigned SPR_RSVD_W   = 10;
  localparam int unsigned SPR_INFO_W   = 2 + 2 * SPR_COORD_W + SPR_RSVD_W;
  localparam int unsigned BEAM_W       = 10;
  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned CMP_W        = 17;

  typedef struct packed {
    logic [PAT_FIELD_W-1:0] base;
    logic [PAT_FIELD_W-1:0] tile_w;
    logic [PAT_FIELD_W-1:0] tile_h;
    logic [PAT_FIELD_W-1:0] draw_w;
    logic [PAT_FIELD_W-1:0] draw_h;
  } pattern_info_t;

  typedef struct packed {
    logic                   en;
    logic                   flip;
    logic [SPR_COORD_W-1:0] x;
    logic [SPR_COORD_W-1:0] y;
    logic [SPR_RSVD_W-1:0]  rsvd;
  } sprite_info_t;

endpackage

// File: rtl/addr_calc.sv
// Per-pixel pattern-memory address generator: region hit test, tile wrap,
// optional horizontal flip, then one registered output stage.
module addr_calc
  import addr_calc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PAT_INFO_W-1:0] pattern_info,
  input  logic [SPR_INFO_W-1:0] sprite_info,
  input  logic [BEAM_W-1:0]     hcount,
  input  logic [BEAM_W-1:0]     vcount,
  output logic [ADDR_W-1:0]     addr_output,
  output logic                  valid
);

  pattern_info_t     pat;
  sprite_info_t      spr;
  logic [CMP_W-1:0]  h_ext, v_ext, x_ext, y_ext, x_end, y_end;
  logic              hit;
  logic [ADDR_W-1:0] rx, ry, tx, ty, tw_mask, th_mask, row_off;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              valid_d, valid_q;

  assign pat = pattern_info_t'(pattern_info);
  assign spr = sprite_info_t'(sprite_info);

  // 17-bit compare domain: x+DW and y+DH can never overflow.
  always_comb begin
    h_ext = CMP_W'(hcount);
    v_ext = CMP_W'(vcount);
    x_ext = CMP_W'(spr.x);
    y_ext = CMP_W'(spr.y);
    x_end = x_ext + CMP_W'(pat.draw_w);
    y_end = y_ext + CMP_W'(pat.draw_h);
    hit   = spr.en && (h_ext >= x_ext) && (h_ext < x_end)
                   && (v_ext >= y_ext) && (v_ext < y_end);
  end

  // NOTE: every combinational output gets a default first so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    rx      = '0;
    ry      = '0;
    tx      = '0;
    ty      = '0;
    row_off = '0;
    tw_mask = pat.tile_w - 16'd1;
    th_mask = pat.tile_h - 16'd1;
    addr_d  = '0;
    valid_d = 1'b0;
    if (hit) begin
      rx      = ADDR_W'(hcount) - ADDR_W'(spr.x);
      ry      = ADDR_W'(vcount) - ADDR_W'(spr.y);
      tx      = rx & tw_mask;
      ty      = ry & th_mask;
      // Flip mirrors within the tile, so it acts on the already-wrapped column.
      if (spr.flip) begin
        tx = tw_mask - tx;
      end
      row_off = ty * pat.tile_w;
      addr_d  = pat.base + row_off + tx;
      valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign addr_output = addr_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_addr_calc.sv
// Self-checking bench for addr_calc: directed cases from the test plan plus
// randomized stimulus scored against an arithmetic reference model.
module tb_addr_calc;
  import addr_calc_pkg::*;

  logic        clk;
  logic        reset;
  logic [79:0] pattern_info;
  logic [31:0] sprite_info;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [15:0] addr_output;
  logic        valid;

  int n_checks = 0;
  int n_pass   = 0;

  addr_calc dut (
    .clk          (clk),
    .reset        (reset),
    .pattern_info (pattern_info),
    .sprite_info  (sprite_info),
    .hcount       (hcount),
    .vcount       (vcount),
    .addr_output  (addr_output),
    .valid        (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [79:0] mk_pat(input int base, input int tw, input int th,
                                         input int dw, input int dh);
    pattern_info_t p;
    p.base   = 16'(base);
    p.tile_w = 16'(tw);
    p.tile_h = 16'(th);
    p.draw_w = 16'(dw);
    p.draw_h = 16'(dh);
    return p;
  endfunction

  function automatic logic [31:0] mk_spr(input bit en, input bit flip, input int x, input int y);
    sprite_info_t s;
    s.en   = en;
    s.flip = flip;
    s.x    = 10'(x);
    s.y    = 10'(y);
    s.rsvd = 10'($urandom);
    return s;
  endfunction

  // Reference model: plain integer arithmetic straight from the field rules.
  function automatic void model(input logic [79:0] p, input logic [31:0] s,
                                input longint h, input longint v,
                                output longint exp_valid, output longint exp_addr);
    longint base, tw, th, dw, dh, x, y, tx, ty;
    base = p[79:64]; tw = p[63:48]; th = p[47:32]; dw = p[31:16]; dh = p[15:0];
    x = s[29:20]; y = s[19:10];
    exp_valid = 0;
    exp_addr  = 0;
    if (s[31] && h >= x && h < x + dw && v >= y && v < y + dh) begin
      tx = (h - x) & ((tw - 1) & 'hFFFF);
      ty = (v - y) & ((th - 1) & 'hFFFF);
      if (s[30]) tx = (((tw - 1) & 'hFFFF) - tx) & 'hFFFF;
      exp_valid = 1;
      exp_addr  = (base + ((ty * tw) % 65536) + tx) % 65536;
    end
  endfunction

  // Drive one pixel, let one edge pass, sample 1 time unit later.
  task automatic drive(input logic [79:0] p, input logic [31:0] s, input int h, input int v);
    pattern_info = p;
    sprite_info  = s;
    hcount       = 10'(h);
    vcount       = 10'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [79:0] p, input logic [31:0] s,
                          input int h, input int v, input longint ev, input longint ea);
    drive(p, s, h, v);
    check({tag, ".valid"}, valid, ev);
    check({tag, ".addr"}, addr_output, ea);
  endtask

  logic [79:0] pat0;
  logic [31:0] spr0;

  initial begin
    longint ev, ea;
    int tw, th, x, y, dw, dh, h, v;

    reset = 1'b0;
    pat0  = mk_pat(0, 16, 16, 650, 32);
    spr0  = mk_spr(1, 0, 0, 368);
    pattern_info = pat0;
    sprite_info  = spr0;
    hcount = 10'd5;
    vcount = 10'd368;
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", valid, 0);
    check("reset.addr", addr_output, 0);
    #3 reset = 1'b1;

    directed("basic0", pat0, spr0, 5, 368, 1, 5);
    directed("basic1", pat0, spr0, 20, 370, 1, 36);
    directed("corner", pat0, spr0, 649, 399, 1, 249);
    directed("h_out", pat0, spr0, 650, 399, 0, 0);
    directed("v_low", pat0, spr0, 5, 367, 0, 0);
    directed("v_high", pat0, spr0, 5, 400, 0, 0);
    directed("flip", pat0, mk_spr(1, 1, 0, 368), 5, 368, 1, 10);
    directed("base", mk_pat(16'h0100, 16, 16, 650, 32), spr0, 5, 368, 1, 16'h0105);
    directed("disable", pat0, mk_spr(0, 0, 0, 368), 5, 368, 0, 0);
    directed("dw_zero", mk_pat(0, 16, 16, 0, 32), spr0, 0, 368, 0, 0);
    directed("wrap", mk_pat(16'hFFFF, 16, 16, 650, 32), spr0, 1, 368, 1, 0);

    // Mid-cycle asynchronous reset, then recovery on the first edge.
    repeat (3) drive(pat0, spr0, 20, 370);
    check("pre_rst.addr", addr_output, 36);
    #2 reset = 1'b0;
    #1;
    check("async_rst.valid", valid, 0);
    check("async_rst.addr", addr_output, 0);
    @(posedge clk);
    #1;
    check("held_rst.valid", valid, 0);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst.valid", valid, 1);
    check("post_rst.addr", addr_output, 36);

    // Randomized: power-of-two tiles, beam biased near the sprite origin.
    for (int i = 0; i < 400; i++) begin
      tw = 1 << $urandom_range(0, 9);
      th = 1 << $urandom_range(0, 9);
      if ($urandom_range(0, 9) == 0) tw = $urandom_range(0, 700);
      x  = $urandom_range(0, 1023);
      y  = $urandom_range(0, 1023);
      dw = $urandom_range(0, 700);
      dh = $urandom_range(0, 700);
      h  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023)
                                       : (x + $urandom_range(0, 700)) % 1024;
      v  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023)
                                       : (y + $urandom_range(0, 700)) % 1024;
      pat0 = mk_pat($urandom_range(0, 65535), tw, th, dw, dh);
      spr0 = mk_spr($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), x, y);
      model(pat0, spr0, h, v, ev, ea);
      drive(pat0, spr0, h, v);
      check("rand.valid", valid, ev);
      check("rand.addr", addr_output, ea);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
